fifo_sync_param: RTL

//  Parametrised synchronous FIFO; next generation of the push/pop FIFO DUV.

---
 rtl/fifo_sync_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO.
//
// Features:
//   - Programmable almost-empty and almost-full thresholds.
//   - Fill count output.
//   - Flush input.
//   - Optional first-word-fall-through (FWFT) read mode.
//   - Overflow, underflow and sticky error reporting.
//
// Handshake: push and pop are single-cycle requests sampled on the rising edge.
//   - A push is accepted when the FIFO is not full, or when it is full and a
//     pop arrives in the same cycle (the pop frees a slot).
//   - A pop is accepted when the FIFO is not empty.
//   - A request that is not accepted leaves the contents unchanged. It raises
//     overflow (rejected push) or underflow (rejected pop) for one cycle.
//
// The registered count is the only source of the status flags.
module fifo_sync_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AE_LEVEL = 4,
   parameter int AF_LEVEL = 12,
   parameter int FWFT     = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               data_in,
   input  logic                           clr_err,
   output logic [WIDTH-1:0]               data_out,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty,
   output logic                           almost_empty,
   output logic                           almost_full,
   output logic                           full,
   output logic                           overflow,
   output logic                           underflow,
   output logic                           error,
   output logic                           err_sticky
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   logic             push_ok;
   logic             pop_ok;
   logic             ovf_next;
   logic             udf_next;
   logic [CW-1:0]    count_next;

   // Accept/reject decisions and the next fill level.
   always_comb begin
      push_ok    = 1'b0;
      pop_ok     = 1'b0;
      ovf_next   = 1'b0;
      udf_next   = 1'b0;
      count_next = count;
      pop_ok     = pop & ~empty;
      push_ok    = push & (~full | pop);
      ovf_next   = push & full & ~pop;
      udf_next   = pop & empty;
      count_next = count + CW'(push_ok) - CW'(pop_ok);
   end

   // Pointers, count, status flags and error reporting.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b0;
         almost_full  <= 1'b0;
         full         <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         error        <= 1'b0;
         err_sticky   <= 1'b0;
      end else if (flush) begin
         // Contents are discarded.
         // Any push or pop in this cycle is ignored.
         // err_sticky is left untouched.
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b0;
         almost_full  <= 1'b0;
         full         <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         error        <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         end
         count        <= count_next;
         empty        <= (count_next == '0);
         almost_empty <= (count_next >= CW'(1)) && (count_next <= CW'(AE_LEVEL));
         almost_full  <= (count_next >= CW'(AF_LEVEL)) && (count_next < CW'(DEPTH));
         full         <= (count_next == CW'(DEPTH));
         overflow     <= ovf_next;
         underflow    <= udf_next;
         error        <= ovf_next | udf_next;
         // A new error wins over a simultaneous clear.
         err_sticky   <= (ovf_next | udf_next) | (err_sticky & ~clr_err);
      end
   end

   // Storage write; the array is deliberately not cleared by reset or flush.
   always_ff @(posedge clk) begin
      if (!reset && !flush && push_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         logic [WIDTH-1:0] hold_q;
         // The head word is shown directly.
         // While empty, the last value shown is held.
         assign data_out = empty ? hold_q : mem[rd_ptr];

         // Remember what is on data_out so it can be held once the FIFO drains.
         always_ff @(posedge clk) begin
            if (reset) begin
               hold_q <= '0;
            end else begin
               hold_q <= data_out;
            end
         end
      end else begin : g_reg
         logic [WIDTH-1:0] dout_q;
         assign data_out = dout_q;

         // Registered read: the popped word appears after the accepting edge.
         always_ff @(posedge clk) begin
            if (reset) begin
               dout_q <= '0;
            end else if (!flush && pop_ok) begin
               dout_q <= mem[rd_ptr];
            end
         end
      end
   endgenerate

endmodule
